// File: rtl/mem_port_arbiter_if.sv
// Bundles the decode, writeback and memory-side signals of the shared memory port.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              dec_req;
    logic [ADDR_W-1:0] dec_addr;
    logic              dec_gnt;
    logic              dec_rvalid;
    logic [DATA_W-1:0] dec_rdata;
    logic              dec_stall;

    logic              wb_req;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_gnt;
    logic              wb_rvalid;
    logic [DATA_W-1:0] wb_rdata;

    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [7:0]        conflict_cnt;

    modport slave (
        input  dec_req, dec_addr, wb_req, wb_we, wb_addr, wb_wdata, mem_rdata,
        output dec_gnt, dec_rvalid, dec_rdata, dec_stall,
               wb_gnt, wb_rvalid, wb_rdata,
               mem_rd_en, mem_wr_en, mem_addr, mem_wdata, conflict_cnt
    );

    modport master (
        output dec_req, dec_addr, wb_req, wb_we, wb_addr, wb_wdata, mem_rdata,
        input  dec_gnt, dec_rvalid, dec_rdata, dec_stall,
               wb_gnt, wb_rvalid, wb_rdata,
               mem_rd_en, mem_wr_en, mem_addr, mem_wdata, conflict_cnt
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between decode reads and writeback reads/writes.
// Grant and strobe one cycle after the request is sampled, read data three cycles after; waiters simply hold req.
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nxt;
    logic              last_wb;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] dec_rdata_q, wb_rdata_q;
    logic              dec_rvalid_q, wb_rvalid_q;
    logic [7:0]        cnt_q;

    logic              grant_now, pick_wb;
    logic              dec_gnt, wb_gnt, rd_en, wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_now = 1'b0;
        pick_wb   = bus.wb_req && (!bus.dec_req || !last_wb);
        dec_gnt   = 1'b0;
        wb_gnt    = 1'b0;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.dec_req || bus.wb_req) begin
                    state_nxt = ACCESS;
                    grant_now = 1'b1;
                end
            end
            ACCESS: begin
                state_nxt = we_q ? IDLE : RESP;
                rd_en     = !we_q;
                wr_en     = we_q;
                dec_gnt   = !last_wb;
                wb_gnt    = last_wb;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // last_wb doubles as the owner of the transaction in flight: it only changes on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wb <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_now) begin
            last_wb <= pick_wb;
            we_q    <= pick_wb && bus.wb_we;
            addr_q  <= pick_wb ? bus.wb_addr : bus.dec_addr;
            if (pick_wb) wdata_q <= bus.wb_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_rvalid_q <= 1'b0;
            wb_rvalid_q  <= 1'b0;
            dec_rdata_q  <= '0;
            wb_rdata_q   <= '0;
        end else begin
            dec_rvalid_q <= (state == RESP) && !last_wb;
            wb_rvalid_q  <= (state == RESP) && last_wb;
            if (state == RESP) begin
                if (last_wb) wb_rdata_q  <= bus.mem_rdata;
                else         dec_rdata_q <= bus.mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= 8'd0;
        else if (bus.dec_req && bus.wb_req && !dec_gnt && !wb_gnt && cnt_q != 8'hFF)
            cnt_q <= cnt_q + 8'd1;
    end

    assign bus.dec_gnt      = dec_gnt;
    assign bus.wb_gnt       = wb_gnt;
    assign bus.mem_rd_en    = rd_en;
    assign bus.mem_wr_en    = wr_en;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.dec_rvalid   = dec_rvalid_q;
    assign bus.wb_rvalid    = wb_rvalid_q;
    assign bus.dec_rdata    = dec_rdata_q;
    assign bus.wb_rdata     = wb_rdata_q;
    assign bus.conflict_cnt = cnt_q;
    assign bus.dec_stall    = bus.dec_req || (!last_wb && state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a random run against a
// transaction-timeline model (grant at +1, bus free at +2 for writes / +3 for reads).
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus_if ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one transaction timeline described by the cycles its events land in.
    int          cyc, free_at, gnt_at, rv_at, e_cnt;
    bit          m_last_wb, g_wb, g_we, pick;
    logic [15:0] g_addr, g_wdata, e_dec_rdata, e_wb_rdata;
    bit          e_dec_gnt, e_wb_gnt, e_rd, e_wr, e_dec_rv, e_wb_rv, e_stall, busy;

    task model_reset();
        cyc = 0; free_at = 0; gnt_at = -100; rv_at = -100; e_cnt = 0;
        m_last_wb = 1'b1; g_wb = 1'b1; g_we = 1'b0;
        g_addr = 16'h0; g_wdata = 16'h0; e_dec_rdata = 16'h0; e_wb_rdata = 16'h0;
    endtask

    task model_expect();
        busy      = (cyc >= gnt_at) && (cyc < free_at);
        e_dec_gnt = (cyc == gnt_at) && !g_wb;
        e_wb_gnt  = (cyc == gnt_at) && g_wb;
        e_rd      = (cyc == gnt_at) && !g_we;
        e_wr      = (cyc == gnt_at) && g_we;
        e_dec_rv  = (cyc == rv_at) && !g_wb;
        e_wb_rv   = (cyc == rv_at) && g_wb;
        e_stall   = bus_if.dec_req || (busy && !g_wb);
    endtask

    task model_advance();
        if (bus_if.dec_req && bus_if.wb_req && cyc != gnt_at && e_cnt < 255) e_cnt++;
        if (cyc == rv_at - 1) begin
            if (g_wb) e_wb_rdata  = bus_if.mem_rdata;
            else      e_dec_rdata = bus_if.mem_rdata;
        end
        if (cyc >= free_at && (bus_if.dec_req || bus_if.wb_req)) begin
            pick      = bus_if.wb_req && (!bus_if.dec_req || !m_last_wb);
            m_last_wb = pick;
            g_wb      = pick;
            g_we      = pick && bus_if.wb_we;
            g_addr    = pick ? bus_if.wb_addr : bus_if.dec_addr;
            if (pick) g_wdata = bus_if.wb_wdata;
            gnt_at    = cyc + 1;
            free_at   = g_we ? cyc + 2 : cyc + 3;
            rv_at     = g_we ? -100 : cyc + 3;
        end
        cyc++;
    endtask

    task sample();
        @(negedge clk);
        model_expect();
    endtask

    task next_cycle();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task do_reset();
        bus_if.dec_req = 0; bus_if.dec_addr = 0;
        bus_if.wb_req = 0; bus_if.wb_we = 0; bus_if.wb_addr = 0; bus_if.wb_wdata = 0;
        bus_if.mem_rdata = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [6:0] ctrl_vec();
        return {bus_if.dec_gnt, bus_if.wb_gnt, bus_if.dec_rvalid, bus_if.wb_rvalid,
                bus_if.mem_rd_en, bus_if.mem_wr_en, bus_if.dec_stall};
    endfunction

    task test_reset();
        do_reset();
        sample();
        n_cmp++; if (ctrl_vec() !== 7'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want 0000000", ctrl_vec()); end
        n_cmp++; if (bus_if.mem_addr !== 16'h0 || bus_if.mem_wdata !== 16'h0) begin n_err++;
            $display("FAIL reset_mem: got addr %h wdata %h want 0000 0000", bus_if.mem_addr, bus_if.mem_wdata); end
        n_cmp++; if (bus_if.dec_rdata !== 16'h0 || bus_if.wb_rdata !== 16'h0) begin n_err++;
            $display("FAIL reset_rdata: got %h %h want 0000 0000", bus_if.dec_rdata, bus_if.wb_rdata); end
        n_cmp++; if (bus_if.conflict_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", bus_if.conflict_cnt); end
        next_cycle();
    endtask

    task test_dec_read();
        do_reset();
        bus_if.dec_req = 1; bus_if.dec_addr = 16'h0012;
        sample();
        n_cmp++; if (ctrl_vec() !== 7'b0000001) begin n_err++; $display("FAIL dec_read_c0: got %b want 0000001", ctrl_vec()); end
        next_cycle();
        bus_if.dec_addr = 16'h5555;
        sample();
        n_cmp++; if (ctrl_vec() !== 7'b1000101 || bus_if.mem_addr !== 16'h0012) begin n_err++;
            $display("FAIL dec_read_c1: got %b addr %h want 1000101 addr 0012", ctrl_vec(), bus_if.mem_addr); end
        next_cycle();
        bus_if.dec_req = 0; bus_if.mem_rdata = 16'hBEEF;
        sample();
        n_cmp++; if (ctrl_vec() !== 7'b0000001) begin n_err++; $display("FAIL dec_read_c2: got %b want 0000001", ctrl_vec()); end
        next_cycle();
        bus_if.mem_rdata = 16'h0000;
        sample();
        n_cmp++; if (ctrl_vec() !== 7'b0010000 || bus_if.dec_rdata !== 16'hBEEF) begin n_err++;
            $display("FAIL dec_read_c3: got %b data %h want 0010000 data beef", ctrl_vec(), bus_if.dec_rdata); end
        next_cycle();
        sample();
        n_cmp++; if (ctrl_vec() !== 7'b0 || bus_if.dec_rdata !== 16'hBEEF) begin n_err++;
            $display("FAIL dec_read_hold: got %b data %h want 0000000 data beef", ctrl_vec(), bus_if.dec_rdata); end
        next_cycle();
    endtask

    task test_wb_write_back_to_back();
        do_reset();
        bus_if.wb_req = 1; bus_if.wb_we = 1; bus_if.wb_addr = 16'h0100; bus_if.wb_wdata = 16'h1234;
        sample();
        next_cycle();
        sample();
        n_cmp++; if (ctrl_vec() !== 7'b0100010 || bus_if.mem_addr !== 16'h0100 || bus_if.mem_wdata !== 16'h1234) begin n_err++;
            $display("FAIL wb_write_c1: got %b addr %h wdata %h want 0100010 addr 0100 wdata 1234",
                     ctrl_vec(), bus_if.mem_addr, bus_if.mem_wdata); end
        next_cycle();
        bus_if.wb_req = 0; bus_if.wb_wdata = 16'hFFFF;
        bus_if.dec_req = 1; bus_if.dec_addr = 16'h0042;
        sample();
        n_cmp++; if (ctrl_vec() !== 7'b0000001) begin n_err++; $display("FAIL wb_write_c2: got %b want 0000001", ctrl_vec()); end
        next_cycle();
        sample();
        n_cmp++; if (ctrl_vec() !== 7'b1000101 || bus_if.mem_addr !== 16'h0042) begin n_err++;
            $display("FAIL back_to_back_gnt: got %b addr %h want 1000101 addr 0042", ctrl_vec(), bus_if.mem_addr); end
        next_cycle();
        bus_if.dec_req = 0;
        for (int i = 0; i < 3; i++) begin
            sample();
            n_cmp++; if (bus_if.wb_rvalid !== 1'b0 || bus_if.mem_wr_en !== 1'b0) begin n_err++;
                $display("FAIL wb_write_no_rvalid: got rvalid %b wr %b want 0 0", bus_if.wb_rvalid, bus_if.mem_wr_en); end
            next_cycle();
        end
    endtask

    task test_tie_alternate();
        bit expect_wb;
        do_reset();
        expect_wb = 1'b0;
        bus_if.dec_req = 1; bus_if.wb_req = 1; bus_if.wb_we = 0;
        bus_if.dec_addr = 16'h0AAA; bus_if.wb_addr = 16'h0BBB;
        for (int i = 0; i < 40; i++) begin
            sample();
            n_cmp++; if ({bus_if.dec_gnt, bus_if.wb_gnt} !== {e_dec_gnt, e_wb_gnt} || bus_if.conflict_cnt !== 8'(e_cnt)) begin n_err++;
                $display("FAIL tie_cycle%0d: got gnt %b%b cnt %0d want gnt %b%b cnt %0d", i, bus_if.dec_gnt, bus_if.wb_gnt,
                         bus_if.conflict_cnt, e_dec_gnt, e_wb_gnt, e_cnt); end
            if (e_dec_gnt || e_wb_gnt) begin
                n_cmp++; if (bus_if.wb_gnt !== expect_wb || bus_if.dec_gnt !== !expect_wb) begin n_err++;
                    $display("FAIL tie_order: got dec %b wb %b want dec %b wb %b", bus_if.dec_gnt, bus_if.wb_gnt, !expect_wb, expect_wb); end
                expect_wb = !expect_wb;
            end
            next_cycle();
        end
        bus_if.dec_req = 0; bus_if.wb_req = 0;
    endtask

    task test_saturate();
        do_reset();
        bus_if.dec_req = 1; bus_if.wb_req = 1; bus_if.wb_we = 0;
        for (int i = 0; i < 600; i++) begin
            sample();
            n_cmp++; if (bus_if.conflict_cnt !== 8'(e_cnt)) begin n_err++;
                $display("FAIL saturate_cycle%0d: got %0d want %0d", i, bus_if.conflict_cnt, e_cnt); end
            next_cycle();
        end
        sample();
        n_cmp++; if (bus_if.conflict_cnt !== 8'd255) begin n_err++; $display("FAIL saturate_final: got %0d want 255", bus_if.conflict_cnt); end
        next_cycle();
        bus_if.dec_req = 0; bus_if.wb_req = 0;
    endtask

    task test_reset_mid();
        do_reset();
        bus_if.dec_req = 1; bus_if.dec_addr = 16'h0012;
        sample(); next_cycle();
        sample(); next_cycle();
        bus_if.dec_req = 0; bus_if.mem_rdata = 16'hBEEF;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (ctrl_vec() !== 7'b0 || bus_if.mem_addr !== 16'h0 || bus_if.dec_rdata !== 16'h0 || bus_if.conflict_cnt !== 8'd0) begin n_err++;
            $display("FAIL reset_mid_async: got %b addr %h data %h cnt %0d want 0000000 0000 0000 0", ctrl_vec(),
                     bus_if.mem_addr, bus_if.dec_rdata, bus_if.conflict_cnt); end
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            sample();
            n_cmp++; if (bus_if.dec_rvalid !== 1'b0 || bus_if.dec_stall !== 1'b0) begin n_err++;
                $display("FAIL reset_mid_after%0d: got rvalid %b stall %b want 0 0", i, bus_if.dec_rvalid, bus_if.dec_stall); end
            next_cycle();
        end
        bus_if.dec_req = 1; bus_if.dec_addr = 16'h0077;
        sample();
        n_cmp++; if (bus_if.dec_stall !== 1'b1 || bus_if.dec_gnt !== 1'b0) begin n_err++;
            $display("FAIL reset_mid_fresh: got stall %b gnt %b want 1 0", bus_if.dec_stall, bus_if.dec_gnt); end
        next_cycle();
        sample();
        n_cmp++; if (bus_if.dec_gnt !== 1'b1 || bus_if.mem_addr !== 16'h0077) begin n_err++;
            $display("FAIL reset_mid_regrant: got gnt %b addr %h want 1 0077", bus_if.dec_gnt, bus_if.mem_addr); end
        next_cycle();
        bus_if.dec_req = 0;
    endtask

    task test_abandon();
        do_reset();
        bus_if.wb_req = 1; bus_if.wb_we = 0; bus_if.wb_addr = 16'h0200;
        sample(); next_cycle();
        bus_if.dec_req = 1; bus_if.dec_addr = 16'h0033;
        sample();
        n_cmp++; if (ctrl_vec() !== 7'b0100101) begin n_err++; $display("FAIL abandon_c1: got %b want 0100101", ctrl_vec()); end
        next_cycle();
        bus_if.wb_req = 0; bus_if.dec_req = 0;
        for (int i = 0; i < 6; i++) begin
            sample();
            n_cmp++; if (bus_if.dec_gnt !== 1'b0 || bus_if.mem_rd_en !== 1'b0 || bus_if.mem_wr_en !== 1'b0) begin n_err++;
                $display("FAIL abandon_after%0d: got gnt %b rd %b wr %b want 0 0 0", i, bus_if.dec_gnt, bus_if.mem_rd_en, bus_if.mem_wr_en); end
            next_cycle();
        end
    endtask

    task test_random();
        bit dg, wg;
        do_reset();
        dg = 0; wg = 0;
        for (int i = 0; i < 2000; i++) begin
            if (dg) bus_if.dec_req = 0;
            else if (!bus_if.dec_req) begin
                if ($urandom_range(2) == 0) begin bus_if.dec_req = 1; bus_if.dec_addr = 16'($urandom); end
            end else if ($urandom_range(15) == 0) bus_if.dec_req = 0;
            else if ($urandom_range(1) == 0) bus_if.dec_addr = 16'($urandom);
            if (wg) bus_if.wb_req = 0;
            else if (!bus_if.wb_req) begin
                if ($urandom_range(2) == 0) begin
                    bus_if.wb_req = 1; bus_if.wb_we = 1'($urandom); bus_if.wb_addr = 16'($urandom); bus_if.wb_wdata = 16'($urandom);
                end
            end else if ($urandom_range(15) == 0) bus_if.wb_req = 0;
            else if ($urandom_range(1) == 0) begin
                bus_if.wb_we = 1'($urandom); bus_if.wb_addr = 16'($urandom); bus_if.wb_wdata = 16'($urandom);
            end
            bus_if.mem_rdata = 16'($urandom);
            sample();
            n_cmp++; if (ctrl_vec() !== {e_dec_gnt, e_wb_gnt, e_dec_rv, e_wb_rv, e_rd, e_wr, e_stall}) begin n_err++;
                $display("FAIL rand_ctrl%0d: got %b want %b", i, ctrl_vec(), {e_dec_gnt, e_wb_gnt, e_dec_rv, e_wb_rv, e_rd, e_wr, e_stall}); end
            if (e_rd || e_wr) begin
                n_cmp++; if (bus_if.mem_addr !== g_addr || (e_wr && bus_if.mem_wdata !== g_wdata)) begin n_err++;
                    $display("FAIL rand_mem%0d: got addr %h wdata %h want addr %h wdata %h", i, bus_if.mem_addr, bus_if.mem_wdata, g_addr, g_wdata); end
            end
            n_cmp++; if (bus_if.dec_rdata !== e_dec_rdata || bus_if.wb_rdata !== e_wb_rdata) begin n_err++;
                $display("FAIL rand_rdata%0d: got %h %h want %h %h", i, bus_if.dec_rdata, bus_if.wb_rdata, e_dec_rdata, e_wb_rdata); end
            n_cmp++; if (bus_if.conflict_cnt !== 8'(e_cnt)) begin n_err++;
                $display("FAIL rand_cnt%0d: got %0d want %0d", i, bus_if.conflict_cnt, e_cnt); end
            dg = e_dec_gnt; wg = e_wb_gnt;
            next_cycle();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_dec_read();
        test_wb_write_back_to_back();
        test_tie_alternate();
        test_saturate();
        test_reset_mid();
        test_abandon();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 16, memory address width.
REQ-002 Parameter: DATA_W, default 16, memory data width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 dec_req  input  1  decode-stage operand read request; held high until dec_gnt.
REQ-006 dec_addr  input  ADDR_W  decode read address.
REQ-007 dec_gnt  output  1  one-cycle grant pulse to decode.
REQ-008 dec_rvalid  output  1  one-cycle pulse, dec_rdata valid.
REQ-009 dec_rdata  output  DATA_W  read data for decode.
REQ-010 dec_stall  output  1  decode must hold its instruction.
REQ-011 wb_req  input  1  writeback-stage access request; held high until wb_gnt.
REQ-012 wb_we  input  1  1 = write, 0 = read.
REQ-013 wb_addr  input  ADDR_W  writeback address.
REQ-014 wb_wdata  input  DATA_W  writeback write data.
REQ-015 wb_gnt  output  1  one-cycle grant pulse to writeback.
REQ-016 wb_rvalid  output  1  one-cycle pulse, wb_rdata valid (reads only).
REQ-017 wb_rdata  output  DATA_W  read data for writeback.
REQ-018 mem_rd_en  output  1  memory read strobe.
REQ-019 mem_wr_en  output  1  memory write strobe.
REQ-020 mem_addr  output  ADDR_W  memory address.
REQ-021 mem_wdata  output  DATA_W  memory write data.
REQ-022 mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_rd_en.
REQ-023 conflict_cnt  output  8  saturating count of cycles both requesters wait.

Function
REQ-024 FSM states: IDLE, ACCESS, RESP; exactly one memory transaction outstanding.
REQ-025 IDLE: if any req sampled high, next state ACCESS, owner latched, address/wdata/we captured at that edge; otherwise stay IDLE.
REQ-026 Arbitration: single req wins; both high -> grant requester not owning the previous transaction (round-robin), last_owner bit updated on every grant.
REQ-027 ACCESS (one cycle): mem_addr/mem_wdata driven from registers, mem_rd_en=1 for reads, mem_wr_en=1 for writes, owner's gnt=1; never both strobes high.
REQ-028 ACCESS exit: write -> IDLE; read -> RESP.
REQ-029 RESP (one cycle): mem_rdata captured into owner's rdata register; next state IDLE; owner's rvalid=1 in the following cycle.
REQ-030 Latency from req sampled in IDLE: gnt at +1, write strobe at +1, rvalid at +3.
REQ-031 A new grant decision is made in the same cycle rvalid is high (back-to-back permitted); writes allow a new decision the cycle after gnt.
REQ-032 Inputs addr/wdata/we changing while waiting have no effect until the capture edge; changes after capture are ignored.
REQ-033 req dropped before grant: request abandoned, no gnt, no memory strobe.
REQ-034 Non-owner rdata registers hold their previous value.
REQ-035 dec_stall = dec_req OR (owner==dec AND state in {ACCESS, RESP}); combinational; low in the cycle dec_rvalid=1 unless dec_req is high.
REQ-036 conflict_cnt increments each cycle dec_req and wb_req are both high and that requester is not receiving gnt; saturates at 255; no wrap.

Reset
REQ-037 rst_n low asynchronously forces state IDLE, all strobes/gnt/rvalid/stall-contributing state 0, mem_addr/mem_wdata/rdata registers 0, conflict_cnt 0, last_owner=wb (decode wins first tie).
REQ-038 Reset mid-transaction aborts it: no rvalid generated after rst_n release; first grant requires a fresh sample in IDLE.

Verification
REQ-039 dec_req=1, dec_addr=0x0012, mem_rdata=0xBEEF at +2 -> dec_gnt+mem_rd_en at +1, dec_rvalid=1 with dec_rdata=0xBEEF at +3.
REQ-040 wb_req=1, wb_we=1, wb_addr=0x0100, wb_wdata=0x1234 -> mem_wr_en=1, mem_addr=0x0100, mem_wdata=0x1234, wb_gnt=1 at +1; no wb_rvalid.
REQ-041 dec_req and wb_req both high from reset, held -> dec granted first, then wb, alternating; conflict_cnt increments only in cycles both wait.
REQ-042 Both requests held continuously 300 cycles with no grants possible (forced via held ACCESS/RESP) -> conflict_cnt reaches 255 and stays 255.
REQ-043 rst_n low during RESP of a dec read -> all outputs 0 immediately; after release no dec_rvalid; dec_stall follows dec_req only.
REQ-044 dec_req pulsed 1 then 0 while wb owns bus -> no dec_gnt, no extra memory strobe.
